bnn_param_loader: RTL and testbench

//  Upstream stage of the 2-2-1 XNOR BNN core. Sequentially reads the 6 weights and 3 biases
//  of the network from a single-port synchronous parameter ROM, buffers them in registers and

---
 rtl/bnn_pkg.sv | 23 ++
 rtl/bnn_param_loader.sv | 129 ++++++++++++
 tb/tb_bnn_param_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the 2-2-1 XNOR BNN datapath.
// Contents: parameter-word geometry (W, N_WT, N_B, AW), the ROM address map
// (weights from WT_BASE, biases from B_BASE), the parameter-loader FSM state
// type and the signed parameter word type.
package bnn_pkg;

  localparam int unsigned W       = 16;
  localparam int unsigned N_WT    = 6;
  localparam int unsigned N_B     = 3;
  localparam int unsigned AW      = 4;
  localparam int unsigned WT_BASE = 0;
  localparam int unsigned B_BASE  = N_WT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } ldr_state_t;

  typedef logic signed [W-1:0] param_t;

endpackage

// File: rtl/bnn_param_loader.sv
// Parameter loader for the BNN core: streams the N_WT weights and N_B biases
// out of a single-port synchronous ROM (1-cycle read latency), buffers them and
// presents them in parallel, flagging params_valid only for a complete set.
// Ports:
//   Clk, Reset     clock and synchronous active-high reset
//   load_req       request a (re)load; ignored while a load is in progress
//   rom_en/addr    ROM read strobe and address (address holds when idle)
//   rom_data       ROM word, valid the cycle after rom_en
//   wt_out, b_out  buffered weights and biases
//   params_valid   complete set loaded and stable
//   busy           load in progress
//   load_done      one-cycle pulse as the final word is being captured
module bnn_param_loader #(
  parameter int unsigned W    = bnn_pkg::W,
  parameter int unsigned N_WT = bnn_pkg::N_WT,
  parameter int unsigned N_B  = bnn_pkg::N_B,
  parameter int unsigned AW   = bnn_pkg::AW
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                load_req,
  output logic                rom_en,
  output logic [AW-1:0]       rom_addr,
  input  logic signed [W-1:0] rom_data,
  output logic signed [W-1:0] wt_out [N_WT],
  output logic signed [W-1:0] b_out  [N_B],
  output logic                params_valid,
  output logic                busy,
  output logic                load_done
);
  import bnn_pkg::*;

  localparam int unsigned BIAS_BASE = WT_BASE + N_WT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_WT + N_B - 1);

  ldr_state_t          state_q, state_d;
  logic                rom_en_q, rom_en_d;
  logic [AW-1:0]       rom_addr_q, rom_addr_d;   // doubles as the fetch counter
  logic                cap_en_q, cap_en_d;
  logic [AW-1:0]       cap_addr_q, cap_addr_d;
  logic signed [W-1:0] wt_q [N_WT];
  logic signed [W-1:0] wt_d [N_WT];
  logic signed [W-1:0] b_q  [N_B];
  logic signed [W-1:0] b_d  [N_B];
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Sequencer: issue addresses 0..LAST_ADDR, then one drain cycle for the last word.
  always_comb begin
    state_d    = state_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (load_req) begin
          state_d    = FETCH;
          rom_en_d   = 1'b1;
          rom_addr_d = '0;
        end
      end
      FETCH: begin
        if (rom_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          done_d  = 1'b1;
        end else begin
          rom_en_d   = 1'b1;
          rom_addr_d = rom_addr_q + AW'(1);
        end
      end
      DRAIN:   state_d = READY;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == FETCH) || (state_d == DRAIN);
    valid_d = (state_d == READY);
  end

  // Capture: the read issued last cycle lands now; route it by its delayed address.
  always_comb begin
    cap_en_d   = rom_en_q;
    cap_addr_d = rom_addr_q;
    wt_d       = wt_q;
    b_d        = b_q;
    if (cap_en_q) begin
      for (int unsigned i = 0; i < N_WT; i++) begin
        if (cap_addr_q == AW'(WT_BASE + i)) wt_d[i] = rom_data;
      end
      for (int unsigned j = 0; j < N_B; j++) begin
        if (cap_addr_q == AW'(BIAS_BASE + j)) b_d[j] = rom_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      cap_en_q   <= 1'b0;
      cap_addr_q <= '0;
      wt_q       <= '{default: '0};
      b_q        <= '{default: '0};
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      cap_en_q   <= cap_en_d;
      cap_addr_q <= cap_addr_d;
      wt_q       <= wt_d;
      b_q        <= b_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rom_en       = rom_en_q;
  assign rom_addr     = rom_addr_q;
  assign wt_out       = wt_q;
  assign b_out        = b_q;
  assign params_valid = valid_q;
  assign busy         = busy_q;
  assign load_done    = done_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed self-checking bench for bnn_param_loader with a behavioural
// 1-cycle-latency ROM. Outputs are sampled 1 time unit after each rising edge.
module tb_bnn_param_loader;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               load_req;
  logic               rom_en;
  logic [3:0]         rom_addr;
  logic signed [15:0] rom_data;
  logic signed [15:0] wt_out [6];
  logic signed [15:0] b_out  [3];
  logic               params_valid;
  logic               busy;
  logic               load_done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] rom   [16];
  logic [15:0] exp_w [6];
  logic [15:0] exp_b [3];
  logic [15:0] held_w0;

  bnn_param_loader dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .load_req     (load_req),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .wt_out       (wt_out),
    .b_out        (b_out),
    .params_valid (params_valid),
    .busy         (busy),
    .load_done    (load_done)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: word appears the cycle after the enabled read.
  always @(posedge Clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_params(input string tag);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s wt[%0d]", tag, i), {16'h0000, wt_out[i]}, {16'h0000, exp_w[i]});
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s b[%0d]", tag, i), {16'h0000, b_out[i]}, {16'h0000, exp_b[i]});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rom_en"}, {31'd0, rom_en}, 32'd0);
    chk({tag, " rom_addr"}, {28'd0, rom_addr}, 32'd0);
    chk({tag, " valid"}, {31'd0, params_valid}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, load_done}, 32'd0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s wt[%0d]", tag, i), {16'h0000, wt_out[i]}, 32'd0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s b[%0d]", tag, i), {16'h0000, b_out[i]}, 32'd0);
  endtask

  // Full load from IDLE/READY with cycle-exact checks; expected words in exp_w/exp_b.
  task automatic run_load(input string tag);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk({tag, " t+1 rom_en"}, {31'd0, rom_en}, 32'd1);
    chk({tag, " t+1 addr"}, {28'd0, rom_addr}, 32'd0);
    chk({tag, " t+1 busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " t+1 valid"}, {31'd0, params_valid}, 32'd0);
    chk({tag, " t+1 old wt0"}, {16'h0000, wt_out[0]}, {16'h0000, held_w0});
    for (int k = 1; k < 9; k++) begin
      tick();
      chk($sformatf("%s t+%0d addr", tag, k + 1), {27'd0, rom_en, rom_addr}, {27'd0, 1'b1, 4'(k)});
      chk($sformatf("%s t+%0d valid", tag, k + 1), {31'd0, params_valid}, 32'd0);
    end
    tick();
    chk({tag, " t+10 rom_en"}, {31'd0, rom_en}, 32'd0);
    chk({tag, " t+10 addr hold"}, {28'd0, rom_addr}, 32'd8);
    chk({tag, " t+10 done"}, {31'd0, load_done}, 32'd1);
    chk({tag, " t+10 busy"}, {31'd0, busy}, 32'd1);
    chk({tag, " t+10 valid"}, {31'd0, params_valid}, 32'd0);
    tick();
    chk({tag, " t+11 valid"}, {31'd0, params_valid}, 32'd1);
    chk({tag, " t+11 done"}, {31'd0, load_done}, 32'd0);
    chk({tag, " t+11 busy"}, {31'd0, busy}, 32'd0);
    chk_params({tag, " t+11"});
    tick();
    chk({tag, " t+12 valid"}, {31'd0, params_valid}, 32'd1);
    chk_params({tag, " t+12"});
    held_w0 = exp_w[0];
  endtask

  initial begin
    int en_cnt, val_cnt, done_cnt, overlap_cnt;
    Reset    = 1'b1;
    load_req = 1'b0;
    held_w0  = 16'h0000;
    for (int k = 0; k < 16; k++) rom[k] = 16'h0000;

    // Power-up reset
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("reset c%0d rom_en", c), {31'd0, rom_en}, 32'd0);
    end
    Reset = 1'b0;
    tick();
    chk_all_zero("post-reset");
    tick();
    chk("idle rom_en", {31'd0, rom_en}, 32'd0);

    // Basic load: addr k holds k*0x0101
    for (int k = 0; k < 9; k++) rom[k] = 16'(k * 16'h0101);
    for (int k = 0; k < 6; k++) exp_w[k] = 16'(k * 16'h0101);
    exp_b[0] = 16'h0606; exp_b[1] = 16'h0707; exp_b[2] = 16'h0808;
    run_load("basic");

    // Signed extremes, stored bit-exact (reload from READY)
    rom[0] = 16'h8000; rom[1] = 16'h7FFF; rom[2] = 16'hFFFF;
    rom[3] = 16'h0001; rom[4] = 16'hFFFE; rom[5] = 16'h0002;
    rom[6] = 16'hFFFD; rom[7] = 16'h0000; rom[8] = 16'h0003;
    exp_w[0] = 16'h8000; exp_w[1] = 16'h7FFF; exp_w[2] = 16'hFFFF;
    exp_w[3] = 16'h0001; exp_w[4] = 16'hFFFE; exp_w[5] = 16'h0002;
    exp_b[0] = 16'hFFFD; exp_b[1] = 16'h0000; exp_b[2] = 16'h0003;
    run_load("signed");

    // load_req held 20 cycles from IDLE: one load, then immediate reload
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    held_w0 = 16'h0000;
    tick();
    en_cnt = 0; val_cnt = 0; done_cnt = 0; overlap_cnt = 0;
    load_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rom_en) en_cnt++;
      if (params_valid) val_cnt++;
      if (load_done) done_cnt++;
      if (params_valid && busy) overlap_cnt++;
    end
    load_req = 1'b0;
    chk("held rom reads", 32'(en_cnt), 32'd18);
    chk("held valid cycles", 32'(val_cnt), 32'd1);
    chk("held done pulses", 32'(done_cnt), 32'd1);
    chk("held valid&busy", 32'(overlap_cnt), 32'd0);
    chk("held t+20 addr", {27'd0, rom_en, rom_addr}, {27'd0, 1'b1, 4'd8});
    tick();
    chk("held t+21 done", {31'd0, load_done}, 32'd1);
    tick();
    chk("held t+22 valid", {31'd0, params_valid}, 32'd1);
    chk_params("held");
    held_w0 = exp_w[0];

    // Reload with all 0x1234
    for (int k = 0; k < 9; k++) rom[k] = 16'h1234;
    for (int k = 0; k < 6; k++) exp_w[k] = 16'h1234;
    for (int k = 0; k < 3; k++) exp_b[k] = 16'h1234;
    run_load("reload");

    // Reset at the 4th ROM read, then Reset and load_req together
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    tick(); tick(); tick();
    chk("midrst addr3", {27'd0, rom_en, rom_addr}, {27'd0, 1'b1, 4'd3});
    Reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    load_req = 1'b1;
    tick();
    chk("rst+req rom_en", {31'd0, rom_en}, 32'd0);
    chk("rst+req busy", {31'd0, busy}, 32'd0);
    Reset    = 1'b0;
    load_req = 1'b0;
    tick();
    chk("after rst idle rom_en", {31'd0, rom_en}, 32'd0);
    chk("after rst idle busy", {31'd0, busy}, 32'd0);
    held_w0 = 16'h0000;
    for (int k = 0; k < 9; k++) rom[k] = 16'(16'hA000 + k);
    for (int k = 0; k < 6; k++) exp_w[k] = 16'(16'hA000 + k);
    exp_b[0] = 16'hA006; exp_b[1] = 16'hA007; exp_b[2] = 16'hA008;
    run_load("post-midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
